// File: rtl/stack.sv
// LIFO assignment trail for DPLL search: each entry holds {type, value, variable index}.
// Pops present the removed top entry on registered outputs one edge later.
module stack #(
    parameter int VARIABLE_INDEXES = 128,
    parameter int NUM_VARIABLE     = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        type_in,
    input  logic                        val_in,
    input  logic [VARIABLE_INDEXES-1:0] var_in,
    output logic [VARIABLE_INDEXES-1:0] var_out,
    output logic                        type_out,
    output logic                        val_out,
    output logic                        empty,
    output logic                        full
);

    localparam int CW = $clog2(NUM_VARIABLE + 1);
    localparam int AW = (NUM_VARIABLE > 1) ? $clog2(NUM_VARIABLE) : 1;
    localparam int EW = VARIABLE_INDEXES + 2;

    logic [EW-1:0] entry_mem [NUM_VARIABLE];
    logic [CW-1:0] count;
    logic [CW-1:0] top_cnt;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;
    logic [EW-1:0] top_entry;
    logic [EW-1:0] new_entry;
    logic          do_pop;
    logic          do_swap;
    logic          do_push;

    assign empty     = (count == '0);
    assign full      = (count == CW'(NUM_VARIABLE));
    assign top_cnt   = count - CW'(1);
    assign wr_idx    = count[AW-1:0];
    assign top_idx   = top_cnt[AW-1:0];
    assign top_entry = entry_mem[top_idx];
    assign new_entry = {type_in, val_in, var_in};

    // A pop on a non-empty stack wins; with push also high it becomes an in-place
    // replace of the top, so a full stack can still swap its top entry.
    assign do_swap = pop & ~empty & push;
    assign do_pop  = pop & ~empty & ~push;
    assign do_push = push & ~full & ~(pop & ~empty);

    always_ff @(posedge clock) begin
        if (do_push) begin
            entry_mem[wr_idx] <= new_entry;
        end else if (do_swap) begin
            entry_mem[top_idx] <= new_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            var_out  <= '0;
            type_out <= 1'b0;
            val_out  <= 1'b0;
        end else begin
            if (do_push) begin
                count <= count + CW'(1);
            end else if (do_pop) begin
                count <= top_cnt;
            end
            if (do_pop || do_swap) begin
                type_out <= top_entry[EW-1];
                val_out  <= top_entry[EW-2];
                var_out  <= top_entry[VARIABLE_INDEXES-1:0];
            end
        end
    end

endmodule

// File: tb/tb_stack.sv
// Directed bench for the stack: reset, LIFO ordering, full/empty gating,
// simultaneous push+pop and asynchronous reset in mid-sequence.
module tb_stack;

    localparam int VW = 128;
    localparam int DEPTH = 8;

    logic          clock;
    logic          reset;
    logic          push;
    logic          pop;
    logic          type_in;
    logic          val_in;
    logic [VW-1:0] var_in;
    logic [VW-1:0] var_out;
    logic          type_out;
    logic          val_out;
    logic          empty;
    logic          full;

    int n_cmp = 0;
    int n_err = 0;

    stack #(.VARIABLE_INDEXES(VW), .NUM_VARIABLE(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .type_in  (type_in),
        .val_in   (val_in),
        .var_in   (var_in),
        .var_out  (var_out),
        .type_out (type_out),
        .val_out  (val_out),
        .empty    (empty),
        .full     (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock cycle: drive on negedge, sample 1 time unit after posedge.
    task automatic cyc(input logic pu, input logic po, input logic t, input logic v,
                       input logic [VW-1:0] vr);
        @(negedge clock);
        push = pu; pop = po; type_in = t; val_in = v; var_in = vr;
        @(posedge clock);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; push = 1'b0; pop = 1'b0; type_in = 1'b0; val_in = 1'b0; var_in = '0;
        #1;
        n_cmp++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            n_err++; $display("FAIL reset_flags_async empty=%b full=%b want 1/0", empty, full);
        end
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({var_out, type_out, val_out} !== '0) begin
            n_err++; $display("FAIL reset_outputs var=%0d t=%b v=%b want 0/0/0", var_out, type_out, val_out);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_cmp++;
        if (empty !== 1'b1 || full !== 1'b0 || var_out !== '0) begin
            n_err++; $display("FAIL reset_release empty=%b full=%b var=%0d want 1/0/0", empty, full, var_out);
        end
    endtask

    task automatic test_pop_empty();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        n_cmp++;
        if (empty !== 1'b1 || {var_out, type_out, val_out} !== '0) begin
            n_err++; $display("FAIL pop_empty empty=%b var=%0d t=%b v=%b want 1/0/0/0", empty, var_out, type_out, val_out);
        end
    endtask

    task automatic test_single();
        cyc(1'b1, 1'b0, 1'b1, 1'b1, VW'(69));
        n_cmp++;
        if (empty !== 1'b0 || var_out !== '0) begin
            n_err++; $display("FAIL single_push empty=%b var=%0d want 0/0", empty, var_out);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        n_cmp++;
        if (var_out !== VW'(69) || type_out !== 1'b1 || val_out !== 1'b1 || empty !== 1'b1) begin
            n_err++; $display("FAIL single_pop var=%0d t=%b v=%b empty=%b want 69/1/1/1", var_out, type_out, val_out, empty);
        end
    endtask

    task automatic test_lifo_two();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, VW'(12));
        cyc(1'b1, 1'b0, 1'b1, 1'b1, VW'(13));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        n_cmp++;
        if (var_out !== VW'(13) || type_out !== 1'b1 || val_out !== 1'b1 || empty !== 1'b0) begin
            n_err++; $display("FAIL lifo2_pop1 var=%0d t=%b v=%b empty=%b want 13/1/1/0", var_out, type_out, val_out, empty);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        n_cmp++;
        if (var_out !== VW'(12) || type_out !== 1'b0 || val_out !== 1'b0 || empty !== 1'b1) begin
            n_err++; $display("FAIL lifo2_pop2 var=%0d t=%b v=%b empty=%b want 12/0/0/1", var_out, type_out, val_out, empty);
        end
    endtask

    task automatic test_lifo_four();
        logic [1:0] tv [4];
        tv[0] = 2'b11; tv[1] = 2'b00; tv[2] = 2'b10; tv[3] = 2'b01;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, tv[i][1], tv[i][0], VW'(14 + i));
        for (int i = 3; i >= 0; i--) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
            n_cmp++;
            if (var_out !== VW'(14 + i) || {type_out, val_out} !== tv[i] || empty !== (i == 0)) begin
                n_err++; $display("FAIL lifo4_pop%0d var=%0d tv=%b empty=%b want %0d/%b/%b",
                                  i, var_out, {type_out, val_out}, empty, 14 + i, tv[i], (i == 0));
            end
        end
    endtask

    task automatic test_full();
        logic [3:0] ib;
        for (int i = 1; i <= 9; i++) begin
            ib = 4'(i);
            cyc(1'b1, 1'b0, ib[0], ib[1], VW'(i));
            if (i >= 7) begin
                n_cmp++;
                if (full !== (i >= 8)) begin
                    n_err++; $display("FAIL full_after_push%0d full=%b want %b", i, full, (i >= 8));
                end
            end
        end
        for (int i = 8; i >= 1; i--) begin
            ib = 4'(i);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
            n_cmp++;
            if (var_out !== VW'(i) || type_out !== ib[0] || val_out !== ib[1] || full !== 1'b0) begin
                n_err++; $display("FAIL full_pop%0d var=%0d t=%b v=%b full=%b want %0d/%b/%b/0",
                                  i, var_out, type_out, val_out, full, i, ib[0], ib[1]);
            end
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_err++; $display("FAIL full_drained empty=%b want 1", empty);
        end
    endtask

    task automatic test_back_to_back();
        // push+pop on empty behaves as push only; outputs hold last popped value (entry 1)
        cyc(1'b1, 1'b1, 1'b1, 1'b0, VW'(40));
        n_cmp++;
        if (empty !== 1'b0 || var_out !== VW'(1) || type_out !== 1'b1 || val_out !== 1'b0) begin
            n_err++; $display("FAIL pp_empty empty=%b var=%0d t=%b v=%b want 0/1/1/0", empty, var_out, type_out, val_out);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1, VW'(41));
        cyc(1'b1, 1'b1, 1'b1, 1'b1, VW'(42));
        n_cmp++;
        if (var_out !== VW'(41) || type_out !== 1'b0 || val_out !== 1'b1 || empty !== 1'b0) begin
            n_err++; $display("FAIL pp_swap var=%0d t=%b v=%b empty=%b want 41/0/1/0", var_out, type_out, val_out, empty);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        n_cmp++;
        if (var_out !== VW'(42) || type_out !== 1'b1 || val_out !== 1'b1) begin
            n_err++; $display("FAIL pp_newtop var=%0d t=%b v=%b want 42/1/1", var_out, type_out, val_out);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        n_cmp++;
        if (var_out !== VW'(40) || empty !== 1'b1) begin
            n_err++; $display("FAIL pp_bottom var=%0d empty=%b want 40/1", var_out, empty);
        end
        // full stack: simultaneous push+pop swaps top and stays full
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, VW'(50 + i));
        cyc(1'b1, 1'b1, 1'b0, 1'b1, VW'(99));
        n_cmp++;
        if (var_out !== VW'(57) || full !== 1'b1) begin
            n_err++; $display("FAIL pp_full var=%0d full=%b want 57/1", var_out, full);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        n_cmp++;
        if (var_out !== VW'(99) || val_out !== 1'b1 || full !== 1'b0) begin
            n_err++; $display("FAIL pp_full_pop var=%0d v=%b full=%b want 99/1/0", var_out, val_out, full);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (empty !== 1'b1 || full !== 1'b0 || {var_out, type_out, val_out} !== '0) begin
            n_err++; $display("FAIL mid_reset empty=%b full=%b var=%0d t=%b v=%b want 1/0/0/0/0",
                              empty, full, var_out, type_out, val_out);
        end
        @(negedge clock);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        n_cmp++;
        if (empty !== 1'b1 || var_out !== '0) begin
            n_err++; $display("FAIL after_mid_reset empty=%b var=%0d want 1/0", empty, var_out);
        end
    endtask

    initial begin
        test_reset();
        test_pop_empty();
        test_single();
        test_lifo_two();
        test_lifo_four();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout compared=%0d want completion", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
